alu_core: RTL and testbench

- Registered 8-bit arithmetic/logic unit: two operands, 4-bit operation select, 16 operations.
- Produces a result byte and a carry flag one clock after the inputs are sampled.
- Used as the datapath execution unit; purely feed-forward, with no handshake and no internal state beyond the output registers.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_divider.sv | 36 +++
 rtl/alu_core.sv | 86 ++++++++
 tb/tb_alu_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core datapath slice.
//   - alu_op_e        : 4-bit operation-select codes (OP_ADD .. OP_EQ)
//   - ALU_WIDTH       : default operand/result width
//   - DIV_BY_ZERO_BIT : fill bit of the divide-by-zero result (all ones)
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    // The divide-by-zero result is this bit replicated across the result width,
    // which keeps it valid for any WIDTH.
    localparam logic DIV_BY_ZERO_BIT = 1'b1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider.
// Ports:
//   dividend    in  WIDTH  numerator
//   divisor     in  WIDTH  denominator
//   quotient    out WIDTH  dividend / divisor (all ones when divisor is 0)
//   div_by_zero out 1      divisor is zero
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero
);

    logic [WIDTH:0] rem;

    assign div_by_zero = (divisor == '0);

    // One restoring step per quotient bit, MSB first: shift the next dividend
    // bit into the partial remainder and subtract the divisor when it fits.
    always_comb begin
        rem      = '0;
        quotient = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem         = rem - {1'b0, divisor};
                quotient[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_core.sv
// Registered WIDTH-bit ALU: 16 operations selected by alu_sel, result and
// carry registered one clock after the inputs are sampled.
// carry_out is always the carry of the unsigned sum a+b, whatever the op.
// Build option: define ALU_CORE_DIV_EN to build the divider for op 3;
// without it op 3 returns zero and no divider logic exists.
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   a, b      in  WIDTH  operands
//   alu_sel   in  4      operation select (alu_op_e)
//   alu_out   out WIDTH  registered result
//   carry_out out 1      registered carry of a+b
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out
);

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] div_result;
    logic [WIDTH-1:0] result_nxt;

    assign sum_full = {1'b0, a} + {1'b0, b};
    assign diff     = a - b;
    assign prod_lo  = a * b;

`ifdef ALU_CORE_DIV_EN
    logic [WIDTH-1:0] quotient;
    logic             div_by_zero;

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .dividend    (a),
        .divisor     (b),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    assign div_result = div_by_zero ? {WIDTH{DIV_BY_ZERO_BIT}} : quotient;
`else
    assign div_result = '0;
`endif

    always_comb begin
        result_nxt = '0;
        case (alu_op_e'(alu_sel))
            OP_ADD:  result_nxt = sum_full[WIDTH-1:0];
            OP_SUB:  result_nxt = diff;
            OP_MUL:  result_nxt = prod_lo;
            OP_DIV:  result_nxt = div_result;
            OP_SHL:  result_nxt = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result_nxt = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  result_nxt = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result_nxt = {a[0], a[WIDTH-1:1]};
            OP_AND:  result_nxt = a & b;
            OP_OR:   result_nxt = a | b;
            OP_XOR:  result_nxt = a ^ b;
            OP_NOR:  result_nxt = ~(a | b);
            OP_NAND: result_nxt = ~(a & b);
            OP_XNOR: result_nxt = ~(a ^ b);
            OP_GT:   result_nxt = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   result_nxt = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            alu_out   <= result_nxt;
            carry_out <= sum_full[WIDTH];
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: an arithmetic reference model checked
// every falling edge, directed literal vectors, and randomized traffic with
// occasional mid-cycle resets.
module tb_alu_core;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_sel;
    logic [W-1:0] alu_out;
    logic         carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_out   = '0;
    logic         exp_carry = 1'b0;

    alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_CORE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Reference: results from plain integer arithmetic, masked to 8 bits.
    function automatic int model_out(int x, int y, int sel);
        int r;
        case (sel)
            0:  r = x + y;
            1:  r = x - y + 256;
            2:  r = x * y;
            3:  r = !DIV_EN ? 0 : (y == 0 ? 255 : x / y);
            4:  r = x * 2;
            5:  r = x / 2;
            6:  r = x * 2 + x / 128;
            7:  r = x / 2 + (x % 2) * 128;
            8:  r = x & y;
            9:  r = x | y;
            10: r = x ^ y;
            11: r = 255 - (x | y);
            12: r = 255 - (x & y);
            13: r = 255 - (x ^ y);
            14: r = (x > y) ? 1 : 0;
            default: r = (x == y) ? 1 : 0;
        endcase
        return r % 256;
    endfunction

    function automatic int model_carry(int x, int y);
        return ((x + y) >= 256) ? 1 : 0;
    endfunction

    // Model state: cleared by reset, loaded from the inputs seen at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out   = '0;
            exp_carry = 1'b0;
        end else begin
            exp_out   = W'(model_out(int'(a), int'(b), int'(alu_sel)));
            exp_carry = 1'(model_carry(int'(a), int'(b)));
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (alu_out !== exp_out || carry_out !== exp_carry) begin
            n_fail++;
            $display("FAIL model_compare t=%0t sel=%0d a=%02h b=%02h: got out=%02h c=%0b, need out=%02h c=%0b",
                     $time, alu_sel, a, b, alu_out, carry_out, exp_out, exp_carry);
        end
    end

    task automatic check_lit(string name, logic [W-1:0] want_out, logic want_c);
        n_checks++;
        if (alu_out !== want_out || carry_out !== want_c) begin
            n_fail++;
            $display("FAIL %s: got out=%02h c=%0b, need out=%02h c=%0b",
                     name, alu_out, carry_out, want_out, want_c);
        end
    endtask

    task automatic apply(logic [W-1:0] va, logic [W-1:0] vb, logic [3:0] vs,
                         logic [W-1:0] want_out, logic want_c, string name);
        @(negedge clk);
        a = va; b = vb; alu_sel = vs;
        @(posedge clk);
        #1;
        check_lit(name, want_out, want_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] sweep_exp [16];
    logic [W-1:0] div_zero_exp;

    initial begin
        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
        if (!DIV_EN) sweep_exp[3] = 8'h00;
        div_zero_exp = DIV_EN ? 8'hFF : 8'h00;

        rst_n = 1'b0; a = '0; b = '0; alu_sel = '0;
        #2;
        check_lit("reset_initial", 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mid-cycle reset with a non-zero result already registered.
        apply(8'h0A, 8'h02, 4'd0, 8'h0C, 1'b0, "pre_reset_add");
        #3;
        rst_n = 1'b0;
        #1;
        check_lit("reset_immediate", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_lit("after_release", 8'h0C, 1'b0);

        for (int s = 0; s < 16; s++)
            apply(8'h0A, 8'h02, 4'(s), sweep_exp[s], 1'b0, $sformatf("sweep_sel%0d", s));

        apply(8'hF6, 8'h0A, 4'd0,  8'h00, 1'b1, "add_wrap_carry");
        apply(8'hF6, 8'h0A, 4'd7,  8'h7B, 1'b1, "ror_carry");
        apply(8'hF6, 8'h0A, 4'd1,  8'hEC, 1'b1, "sub_carry");
        apply(8'h0A, 8'h00, 4'd3,  div_zero_exp, 1'b0, "div_by_zero");
        apply(8'h55, 8'h55, 4'd15, 8'h01, 1'b0, "eq_true");
        apply(8'h55, 8'h55, 4'd14, 8'h00, 1'b0, "gt_false");
        apply(8'h55, 8'h55, 4'd2,  8'h39, 1'b0, "mul_low");
        apply(8'hFF, 8'h01, 4'd15, 8'h00, 1'b1, "eq_false_carry");
        apply(8'h80, 8'h7F, 4'd14, 8'h01, 1'b0, "gt_true");

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a       = W'($urandom);
            b       = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            alu_sel = 4'($urandom);
            if (!rst_n) rst_n = 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
